syscall_sequencer: RTL



---
 rtl/syscall_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/syscall_sequencer.sv
// Multi-cycle syscall controller: stalls the single-cycle CPU while a service runs,
// drives the hex display, handshakes switch reads and latches halt on exit.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no service active; a syscall here is accepted at the edge
// S_HOLD   | print service, CPU held while cnt counts down to zero
// S_WAIT_IN| read service, CPU held until sw_valid delivers a value
// S_DONE   | single retire cycle, stall low, syscall ignored
// S_HALTED | exit taken, absorbing until reset
module syscall_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic [15:0] sw_data,
  input  logic        sw_valid,
  output logic        stall,
  output logic        halt,
  output logic [31:0] hex,
  output logic        hex_valid,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        err_unknown
);

  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (HOLD_CYCLES < 1 || (CNT_W < 32 && ((HOLD_CYCLES - 1) >> CNT_W) != 0)) begin : g_param_chk
      $error("syscall_sequencer: HOLD_CYCLES must be >= 1 and HOLD_CYCLES-1 must fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_WAIT_IN = 3'd2,
    S_DONE    = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             halt_nxt;
  logic [31:0]      hex_nxt;
  logic             hex_valid_nxt;
  logic [31:0]      wb_data_nxt;
  logic             wb_we_nxt;
  logic             err_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      halt        <= 1'b0;
      hex         <= '0;
      hex_valid   <= 1'b0;
      wb_data     <= '0;
      wb_we       <= 1'b0;
      err_unknown <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      halt        <= halt_nxt;
      hex         <= hex_nxt;
      hex_valid   <= hex_valid_nxt;
      wb_data     <= wb_data_nxt;
      wb_we       <= wb_we_nxt;
      err_unknown <= err_nxt;
    end
  end

  // wb_we is registered and only set on the WAIT_IN->DONE transition,
  // so it is high for exactly the one DONE cycle of a read.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    halt_nxt      = halt;
    hex_nxt       = hex;
    hex_valid_nxt = hex_valid;
    wb_data_nxt   = wb_data;
    wb_we_nxt     = 1'b0;
    err_nxt       = err_unknown;
    stall         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (syscall) begin
          stall = 1'b1;
          if (v0 == SVC_PRINT_INT || v0 == SVC_PRINT_HEX) begin
            hex_nxt       = a0;
            hex_valid_nxt = 1'b1;
            cnt_nxt       = HOLD_LOAD;
            state_nxt     = S_HOLD;
          end else if (v0 == SVC_READ_INT) begin
            state_nxt = S_WAIT_IN;
          end else if (v0 == SVC_EXIT) begin
            halt_nxt  = 1'b1;
            state_nxt = S_HALTED;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end

      S_HOLD: begin
        stall = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      S_WAIT_IN: begin
        stall = 1'b1;
        if (sw_valid) begin
          wb_data_nxt = {16'b0, sw_data};
          wb_we_nxt   = 1'b1;
          state_nxt   = S_DONE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      S_HALTED: begin
        stall = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
